udiv16by8_seq: RTL and testbench

//  Sequential unsigned restoring divider: WX-bit dividend / WY-bit divisor -> WX-bit quotient, WY-bit remainder.

---
 rtl/udiv16by8_seq.sv | 132 +++++++++++++
 tb/tb_udiv16by8_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/udiv16by8_seq.sv
// udiv16by8_seq: sequential unsigned restoring divider, one quotient bit per cycle.
//   Computes x / y -> quotient q (WX bits) and remainder r (WY bits), x == q*y + r.
//   Divide by zero yields q = all ones and r = x[WY-1:0], with the same latency.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   in_valid   in   operands valid
//   in_ready   out  operands accepted (high only in IDLE)
//   x          in   dividend, WX bits
//   y          in   divisor, WY bits
//   out_valid  out  q/r valid (high only in DONE)
//   out_ready  in   consumer accepts the result
//   dbz        out  divide-by-zero flag (present only with DIV_DBZ_FLAG_EN)
//   q          out  quotient, WX bits, held until the next result
//   r          out  remainder, WY bits, held until the next result
//
// Configuration macro: DIV_DBZ_FLAG_EN adds the dbz output.

module udiv16by8_seq #(
  parameter int unsigned WX = 16,
  parameter int unsigned WY = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WX-1:0] x,
  input  logic [WY-1:0] y,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef DIV_DBZ_FLAG_EN
  output logic          dbz,
`endif
  output logic [WX-1:0] q,
  output logic [WY-1:0] r
);

  localparam int unsigned CW = (WX > 1) ? $clog2(WX) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q;
  logic [CW-1:0] count_q;
  logic [WX-1:0] xq_q;    // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WY-1:0] yq_q;
  logic [WY-1:0] xlo_q;   // low dividend bits, kept for the forced divide-by-zero remainder
  logic [WY-1:0] pr_q;

  logic [WY:0]   pr_shift;
  logic [WY-1:0] pr_next;
  logic          q_bit;
  logic [WX-1:0] xq_next;
  logic          last_step;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign last_step = (count_q == CW'(WX - 1));

  // The stored remainder is always < y, so WY bits hold it; only the shifted
  // trial value needs the extra bit so the comparison never overflows.
  always_comb begin
    pr_shift = {pr_q, xq_q[WX-1]};
    pr_next  = pr_shift[WY-1:0];
    q_bit    = 1'b0;
    if (pr_shift >= {1'b0, yq_q}) begin
      pr_next = WY'(pr_shift - {1'b0, yq_q});
      q_bit   = 1'b1;
    end
    xq_next = {xq_q[WX-2:0], q_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      xq_q    <= '0;
      yq_q    <= '0;
      xlo_q   <= '0;
      pr_q    <= '0;
      q       <= '0;
      r       <= '0;
`ifdef DIV_DBZ_FLAG_EN
      dbz     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            xq_q    <= x;
            yq_q    <= y;
            xlo_q   <= x[WY-1:0];
            pr_q    <= '0;
            count_q <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          xq_q    <= xq_next;
          pr_q    <= pr_next;
          count_q <= count_q + CW'(1);
          if (last_step) begin
            state_q <= DONE;
            if (yq_q == '0) begin
              // Forced result rather than whatever the iteration produced.
              q <= '1;
              r <= xlo_q;
`ifdef DIV_DBZ_FLAG_EN
              dbz <= 1'b1;
`endif
            end else begin
              q <= xq_next;
              r <= pr_next;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
`ifdef DIV_DBZ_FLAG_EN
            dbz     <= 1'b0;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udiv16by8_seq.sv
// Self-checking bench for udiv16by8_seq: directed cases, backpressure, mid-operation
// reset and a randomized stream checked against plain integer division.

module tb_udiv16by8_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x = '0;
  logic [7:0]  y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] q;
  logic [7:0]  r;
`ifdef DIV_DBZ_FLAG_EN
  logic        dbz;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] x;
    logic [7:0]  y;
  } op_t;

  op_t sb[$];

  udiv16by8_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DIV_DBZ_FLAG_EN
    .dbz       (dbz),
`endif
    .q         (q),
    .r         (r)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_q(logic [15:0] a, logic [7:0] b);
    return (b == 0) ? 16'hFFFF : a / {8'd0, b};
  endfunction

  function automatic logic [7:0] model_r(logic [15:0] a, logic [7:0] b);
    logic [15:0] m;
    m = a % {8'd0, b};
    return (b == 0) ? a[7:0] : m[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("issue_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    x = a;
    y = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [7:0] b);
    int lat;
    issue(a, b);
    wait_done(lat);
    check({tag, "_latency"}, lat, 32'd16);
    check({tag, "_q"}, {16'd0, q}, {16'd0, model_q(a, b)});
    check({tag, "_r"}, {24'd0, r}, {24'd0, model_r(a, b)});
`ifdef DIV_DBZ_FLAG_EN
    check({tag, "_dbz"}, {31'd0, dbz}, {31'd0, (b == 0)});
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_one_cycle"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
`ifdef DIV_DBZ_FLAG_EN
    check({tag, "_dbz_clr"}, {31'd0, dbz}, 32'd0);
`endif
  endtask

  initial begin
    int lat;
    int issued;
    int done;
    int cycles;
    bit seen_valid;
    bit iv;
    bit ordrv;
    op_t op;
    logic [31:0] prod;

    // Reset state, observed while reset is still asserted.
    tick();
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_q", {16'd0, q}, 32'd0);
    check("rst_r", {24'd0, r}, 32'd0);
`ifdef DIV_DBZ_FLAG_EN
    check("rst_dbz", {31'd0, dbz}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    directed("t1_1000_7", 16'd1000, 8'd7);
    directed("t2_65535_255", 16'd65535, 8'd255);
    directed("t2_65535_1", 16'd65535, 8'd1);
    directed("t2_5_200", 16'd5, 8'd200);
    directed("t3_dbz", 16'd1234, 8'd0);

    // Backpressure: result held while out_ready is low, in_valid ignored.
    issue(16'd300, 8'd9);
    wait_done(lat);
    check("t4_latency", lat, 32'd16);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      x = 16'd77;
      y = 8'd3;
      tick();
      check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t4_hold_q", {16'd0, q}, {16'd0, model_q(16'd300, 8'd9)});
      check("t4_hold_r", {24'd0, r}, {24'd0, model_r(16'd300, 8'd9)});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_ready_after_hs", {31'd0, in_ready}, 32'd1);
    check("t4_valid_after_hs", {31'd0, out_valid}, 32'd0);
    tick();
    check("t4_no_queued_op", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of an operation.
    issue(16'd50000, 8'd13);
    for (int i = 0; i < 6; i++) tick();
    check("t5_busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_q", {16'd0, q}, 32'd0);
    check("t5_rst_r", {24'd0, r}, 32'd0);
    check("t5_rst_ready", {31'd0, in_ready}, 32'd1);
    #2;
    rst = 1'b0;
    seen_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    out_ready = 1'b0;
    check("t5_no_stale", {31'd0, seen_valid}, 32'd0);
    directed("t5_recover", 16'd4321, 8'd17);

    // Randomized stream with random valid/ready gaps, results in issue order.
    issued = 0;
    done = 0;
    cycles = 0;
    while ((issued < 2000 || done < issued) && cycles < 80000) begin
      ordrv = ($urandom_range(0, 3) != 0);
      if (out_valid && ordrv) begin
        check("t6_sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
          op = sb.pop_front();
          check("t6_q", {16'd0, q}, {16'd0, model_q(op.x, op.y)});
          check("t6_r", {24'd0, r}, {24'd0, model_r(op.x, op.y)});
          prod = {16'd0, q} * {24'd0, op.y} + {24'd0, r};
          check("t6_identity", {31'd0, (prod == {16'd0, op.x}) && (r < op.y)}, 32'd1);
        end
        done++;
      end
      iv = ($urandom_range(0, 2) != 0) && (issued < 2000);
      x = 16'($urandom_range(0, 65535));
      y = 8'($urandom_range(1, 255));
      if (in_ready && iv) begin
        op.x = x;
        op.y = y;
        sb.push_back(op);
        issued++;
      end
      in_valid = iv;
      out_ready = ordrv;
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("t6_completed", done, 32'd2000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
